md_unit: RTL

- Parametrised multiply/divide unit for the next-generation pipelined MIPS core. Sits in the EX stage beside the ALU.
- Executes mult/multu/div/divu/madd/maddu over a configurable number of cycles and holds the HI/LO architectural registers.
- Handles mthi/mtlo writes.
- Exports a busy flag so the hazard unit stalls any md instruction, or mfhi/mflo, issued while an operation is in flight.

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_arith.sv | 72 +++++++
 rtl/md_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// small op-classification helpers.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam logic [2:0] MD_MADD  = 3'd6;
    localparam logic [2:0] MD_MADDU = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // Ops that occupy the unit for a number of cycles (everything but mthi/mtlo).
    function automatic logic is_long_op(input logic [2:0] op);
        return !(op == MD_MTHI || op == MD_MTLO);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV || op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: computes the HI/LO values an
// operation would commit, given the latched operands and current HI/LO.
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MINUS_ONE = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic signed [2*WIDTH-1:0] sprod;
    logic        [2*WIDTH-1:0] uprod;
    logic        [2*WIDTH-1:0] acc;
    logic        [WIDTH-1:0]   b_safe;
    logic signed [WIDTH-1:0]   squot;
    logic signed [WIDTH-1:0]   srem;
    logic        [WIDTH-1:0]   uquot;
    logic        [WIDTH-1:0]   urem;
    logic                      div_ovf;

    always_comb begin
        sprod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        acc   = {hi, lo};

        // A zero divisor is replaced so the dividers never see it; the
        // result is discarded by the caller anyway.
        b_safe  = (b == '0) ? ONE : b;
        squot   = $signed(a) / $signed(b_safe);
        srem    = $signed(a) % $signed(b_safe);
        uquot   = a / b_safe;
        urem    = a % b_safe;
        div_ovf = (a == MOST_NEG) && (b == MINUS_ONE);

        div_by_zero = is_div_op(op) && (b == '0);

        next_hi = hi;
        next_lo = lo;
        case (op)
            MD_MULT:  {next_hi, next_lo} = sprod;
            MD_MULTU: {next_hi, next_lo} = uprod;
            MD_MADD:  {next_hi, next_lo} = acc + $unsigned(sprod);
            MD_MADDU: {next_hi, next_lo} = acc + uprod;
            MD_DIV: begin
                if (div_ovf) begin
                    next_lo = MOST_NEG;
                    next_hi = '0;
                end else begin
                    next_lo = squot;
                    next_hi = srem;
                end
            end
            MD_DIVU: begin
                next_lo = uquot;
                next_hi = urem;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO architectural registers;
// busy stays high for the full latency of each mult/div operation.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_t        state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic [WIDTH-1:0] arith_hi, arith_lo;
    logic             div_by_zero;
    logic             accept;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op         (op_reg),
        .a          (a_reg),
        .b          (b_reg),
        .hi         (hi_reg),
        .lo         (lo_reg),
        .next_hi    (arith_hi),
        .next_lo    (arith_lo),
        .div_by_zero(div_by_zero)
    );

    assign accept = start && !flush && (state_reg == IDLE);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (op == MD_MTHI) begin
                        hi_next = rs_data;
                    end else if (op == MD_MTLO) begin
                        lo_next = rs_data;
                    end else begin
                        state_next = BUSY;
                        count_next = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    end
                end
            end
            BUSY: begin
                count_next = count_reg - CNT_W'(1);
                // Last busy cycle: commit unless the divisor was zero.
                if (count_reg == CNT_W'(1)) begin
                    state_next = IDLE;
                    if (!div_by_zero) begin
                        hi_next = arith_hi;
                        lo_next = arith_lo;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            op_reg    <= MD_MULT;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            if (accept && is_long_op(op)) begin
                op_reg <= op;
                a_reg  <= rs_data;
                b_reg  <= rt_data;
            end
        end
    end

    assign busy = (state_reg == BUSY);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule
